// File: rtl/wb_slave_ram.sv
// wb_slave_ram
// Wishbone classic-cycle slave: a word-addressed synchronous RAM with a
// programmable number of wait states and an error termination for
// out-of-range addresses.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   cyc_i  - bus cycle in progress
//   stb_i  - transfer strobe
//   we_i   - 1 = write, 0 = read
//   adr_i  - word address
//   dat_i  - write data
//   sel_i  - byte lane enables (bit k covers dat_i[8k+7:8k])
//   dat_o  - registered read data, held until the next in-range read
//   ack_o  - registered one-cycle normal termination
//   err_o  - registered one-cycle error termination
module wb_slave_ram #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o
);

  localparam int         SEL_W    = DATA_WIDTH / 8;
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    ack_q, err_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    req;
  logic                    in_range;
  logic                    commit;
  logic [DEPTH_LOG2-1:0]   idx;

  assign req      = cyc_i & stb_i;
  assign in_range = ~|adr_i[ADDR_WIDTH-1:DEPTH_LOG2];
  assign idx      = adr_i[DEPTH_LOG2-1:0];

  // commit marks the edge that enters RESP; the bus values at that edge win.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // A strobe drop, even on the would-be commit edge, abandons the transfer.
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // RESP never samples the bus, so the lingering strobe is not re-taken.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= commit & in_range;
      err_q   <= commit & ~in_range;
      if (commit && in_range && !we_i) begin
        dat_q <= mem_q[idx];
      end
    end
  end

  // Storage is never cleared; a reset only suppresses the pending write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && in_range && we_i) begin
      for (int k = 0; k < SEL_W; k++) begin
        if (sel_i[k]) begin
          mem_q[idx][8*k +: 8] <= dat_i[8*k +: 8];
        end
      end
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_wb_slave_ram.sv
// tb_wb_slave_ram
// Directed bench for wb_slave_ram. Three instances with 1, 3 and 0 wait
// states share the address/data/we/sel lines; each has its own cyc/stb so
// only the targeted instance sees a transfer. Expected terminations are
// queued when a request is driven and popped when the response arrives.
module tb_wb_slave_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cyc = '0;
  logic [2:0]  stb = '0;
  logic        we  = 1'b0;
  logic [15:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;

  logic [2:0]  ack_w;
  logic [2:0]  err_w;
  logic [31:0] dat_w [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  wb_slave_ram #(.WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we),
    .adr_i(adr), .dat_i(dat), .sel_i(sel),
    .dat_o(dat_w[0]), .ack_o(ack_w[0]), .err_o(err_w[0]));

  wb_slave_ram #(.WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we),
    .adr_i(adr), .dat_i(dat), .sel_i(sel),
    .dat_o(dat_w[1]), .ack_o(ack_w[1]), .err_o(err_w[1]));

  wb_slave_ram #(.WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we),
    .adr_i(adr), .dat_i(dat), .sel_i(sel),
    .dat_o(dat_w[2]), .ack_o(ack_w[2]), .err_o(err_w[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic xfer(input string tag, input int d, input logic w, input logic [15:0] a,
                      input logic [31:0] wd, input logic [3:0] s, input logic e_ack,
                      input logic e_err, input logic [31:0] e_dat, input bit keep);
    exp_t e;
    int   n;
    sb.push_back('{tag, e_ack, e_err, e_dat, ws_of(d) + 1});
    we = w; adr = a; dat = wd; sel = s;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack_w[d] | err_w[d]) && n < 20);
    e = sb.pop_front();
    chk({e.tag, ".lat"}, 32'(n), 32'(e.lat));
    chk({e.tag, ".ack"}, 32'(ack_w[d]), 32'(e.ack));
    chk({e.tag, ".err"}, 32'(err_w[d]), 32'(e.err));
    chk({e.tag, ".dat"}, dat_w[d], e.rdat);
    if (!keep) begin
      cyc[d] = 1'b0; stb[d] = 1'b0;
    end
    @(negedge clk);
    chk({e.tag, ".pulse"}, 32'({ack_w[d], err_w[d]}), 32'd0);
  endtask

  task automatic abort_xfer(input string tag, input int d, input logic [15:0] a,
                            input logic [31:0] wd, input int hold);
    logic seen;
    seen = 1'b0;
    we = 1'b1; adr = a; dat = wd; sel = 4'hF;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      seen |= ack_w[d] | err_w[d];
    end
    stb[d] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= ack_w[d] | err_w[d];
    end
    cyc[d] = 1'b0;
    chk({tag, ".noterm"}, 32'(seen), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.ack", 32'(ack_w), 32'd0);
    chk("rst.err", 32'(err_w), 32'd0);
    chk("rst.dat0", dat_w[0], 32'd0);
    chk("rst.dat1", dat_w[1], 32'd0);
    chk("rst.dat2", dat_w[2], 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write/read, one wait state
    xfer("wr3",    0, 1'b1, 16'h0003, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0,        0);
    xfer("rd3",    0, 1'b0, 16'h0003, 32'h0,        4'hF, 1, 0, 32'hDEADBEEF, 0);
    // Byte lanes
    xfer("wr10a",  0, 1'b1, 16'h0010, 32'hFFFFFFFF, 4'hF, 1, 0, 32'hDEADBEEF, 0);
    xfer("wr10b",  0, 1'b1, 16'h0010, 32'h00000000, 4'h5, 1, 0, 32'hDEADBEEF, 0);
    xfer("rd10",   0, 1'b0, 16'h0010, 32'h0,        4'h0, 1, 0, 32'hFF00FF00, 0);
    // Out of range; 0x1000 aliases index 0 if the range check is broken
    xfer("wr0",    0, 1'b1, 16'h0000, 32'hA5A5A5A5, 4'hF, 1, 0, 32'hFF00FF00, 0);
    xfer("rd100",  0, 1'b0, 16'h0100, 32'h0,        4'hF, 0, 1, 32'hFF00FF00, 0);
    xfer("wr1000", 0, 1'b1, 16'h1000, 32'h00000000, 4'hF, 0, 1, 32'hFF00FF00, 0);
    xfer("rd0",    0, 1'b0, 16'h0000, 32'h0,        4'hF, 1, 0, 32'hA5A5A5A5, 0);
    xfer("rd3b",   0, 1'b0, 16'h0003, 32'h0,        4'hF, 1, 0, 32'hDEADBEEF, 0);

    // Aborts with three wait states, including a drop on the would-be commit edge
    xfer("w3wr20", 1, 1'b1, 16'h0020, 32'hCAFEF00D, 4'hF, 1, 0, 32'h0,        0);
    abort_xfer("abort2", 1, 16'h0020, 32'h12345678, 2);
    abort_xfer("abort3", 1, 16'h0020, 32'h12345678, 3);
    xfer("w3rd20", 1, 1'b0, 16'h0020, 32'h0,        4'hF, 1, 0, 32'hCAFEF00D, 0);

    // Zero wait states, two masters re-strobing immediately
    xfer("m0wr40", 2, 1'b1, 16'h0040, 32'h11112222, 4'hF, 1, 0, 32'h0,        1);
    xfer("m1wr41", 2, 1'b1, 16'h0041, 32'h33334444, 4'hF, 1, 0, 32'h0,        1);
    xfer("m0rd40", 2, 1'b0, 16'h0040, 32'h0,        4'hF, 1, 0, 32'h11112222, 1);
    xfer("m1rd41", 2, 1'b0, 16'h0041, 32'h0,        4'hF, 1, 0, 32'h33334444, 0);

    // Reset during WAIT of a write, request still held across the reset edge
    xfer("wr30",   0, 1'b1, 16'h0030, 32'h11111111, 4'hF, 1, 0, 32'hDEADBEEF, 0);
    we = 1'b1; adr = 16'h0030; dat = 32'h22222222; sel = 4'hF;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.ack", 32'(ack_w[0]), 32'd0);
    chk("rstmid.err", 32'(err_w[0]), 32'd0);
    chk("rstmid.dat", dat_w[0], 32'd0);
    chk("rstmid.dat2", dat_w[2], 32'd0);
    rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    xfer("rd30",   0, 1'b0, 16'h0030, 32'h0,        4'hF, 1, 0, 32'h11111111, 0);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_slave_ram.md
# wb_slave_ram

Wishbone classic-cycle slave: a synchronous word-addressed RAM with programmable wait states and a bus-error response for out-of-range addresses. It sits on a slave port of `wb_intercon`, on the responder side of the bus, and replaces `wb_slave_nop` wherever a real data-carrying target is needed. Masters see a single-beat read/write target whose latency is set by a parameter.

## Interface
- `ADDR_WIDTH`, 16: width of `adr_i`, word address.
- `DATA_WIDTH`, 32: data width; must be a multiple of 8.
- `DEPTH_LOG2`, 8: RAM holds 2^DEPTH_LOG2 words.
- `WAIT_STATES`, 1: extra cycles inserted before the response; legal range 0..15.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cyc_i`  in  1  bus cycle in progress.
- `stb_i`  in  1  transfer strobe.
- `we_i`  in  1  1 = write, 0 = read.
- `adr_i`  in  ADDR_WIDTH  word address.
- `dat_i`  in  DATA_WIDTH  write data.
- `sel_i`  in  DATA_WIDTH/8  byte lane enables; bit k covers `dat_i[8k+7:8k]`.
- `dat_o`  out  DATA_WIDTH  read data, registered.
- `ack_o`  out  1  normal termination, registered, one-cycle pulse.
- `err_o`  out  1  error termination, registered, one-cycle pulse.

## Operation
- A request is `cyc_i & stb_i` sampled high in IDLE.
- An address is in range iff `adr_i[ADDR_WIDTH-1:DEPTH_LOG2]` is all zero. The RAM index is `adr_i[DEPTH_LOG2-1:0]`.
- FSM states: IDLE, WAIT, RESP.
  - IDLE → WAIT on a request when WAIT_STATES > 0, loading the counter with WAIT_STATES-1.
  - IDLE → RESP directly on a request when WAIT_STATES = 0.
  - WAIT: the counter decrements each cycle. When the counter is 0 and the request is still present, go to RESP.
  - WAIT → IDLE immediately if `cyc_i` or `stb_i` is low (abort). An abort produces no write, no ack and no err.
  - RESP → IDLE unconditionally after one cycle. Requests are not sampled in RESP, so the still-asserted `stb_i` of the finished transfer is never re-taken.
- Commit happens on the edge that enters RESP, using `adr_i`, `we_i`, `dat_i`, `sel_i` as sampled at that edge:
  - In-range write: update only the bytes whose `sel_i` bit is 1; assert `ack_o`.
  - In-range read: load `dat_o` with the full word (`sel_i` ignored); assert `ack_o`.
  - Out-of-range access: assert `err_o` instead of `ack_o`. No RAM update; `dat_o` unchanged.
- `ack_o` and `err_o` are never high together, and each is high only in RESP.
- `dat_o` holds its value until the next in-range read commit.
- RAM contents are not cleared by reset and are undefined until written.

## Timing
- Reset values: `ack_o`=0, `err_o`=0, `dat_o`=0; state IDLE; counter 0.
- A reset asserted in WAIT or RESP drops any pending transfer with no RAM write, and all outputs take their reset values on the next edge.
- Latency: request sampled at edge N gives `ack_o`/`err_o` high during the cycle after edge N+WAIT_STATES, for exactly one cycle.
- Throughput: one transfer per WAIT_STATES+2 cycles when the master re-strobes immediately.
- Masters hold address, data, `we_i` and `sel_i` stable from request until termination. Changes during WAIT are tolerated; the values at the commit edge win.
- A `cyc_i`/`stb_i` drop on the same edge the FSM would enter RESP counts as an abort.

## Test plan
1. WAIT_STATES=1; write 0xDEADBEEF to address 0x0003 with `sel_i`=0xF, then read 0x0003 → `ack_o` 2 cycles after each request; read `dat_o`=0xDEADBEEF.
2. Byte lanes: write 0xFFFFFFFF to 0x0010, then write 0x00000000 with `sel_i`=0x5, then read → `dat_o`=0xFF00FF00.
3. Out of range: read 0x0100 with DEPTH_LOG2=8 → `err_o` pulse, `ack_o`=0, `dat_o` keeps its previous value. A write to 0x1000 → `err_o` pulse and no RAM word changes.
4. Abort: WAIT_STATES=3; write 0x12345678 to 0x0020, then drop `stb_i` after 2 cycles → no `ack_o`/`err_o` pulse; a later read of 0x0020 returns its prior contents.
5. Reset mid-transfer: assert `rst_i` for one cycle during WAIT of a write to 0x0030 → next cycle `ack_o`=0 and `dat_o`=0; 0x0030 not modified.
6. WAIT_STATES=0 back-to-back via `wb_intercon` with two masters → `ack_o` one cycle after each request, a dead IDLE cycle between transfers, never two consecutive `ack_o` cycles.
